// File: rtl/mem_wr_rd_master_if.sv
// Valid/ready request bus between the memory self-test master and the
// single-port memory.
interface mem_wr_rd_master_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 6
);
  logic                  valid_o;
  logic                  wr_rd_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [WIDTH-1:0]      wdata_o;
  logic [WIDTH-1:0]      rdata_i;
  logic                  ready_i;

  modport master (
    output valid_o, wr_rd_o, addr_o, wdata_o,
    input  rdata_i, ready_i
  );

  modport slave (
    input  valid_o, wr_rd_o, addr_o, wdata_o,
    output rdata_i, ready_i
  );
endinterface

// File: rtl/mem_wr_rd_master.sv
// Memory self-test initiator: writes seed+k over an address range, reads it
// back, compares, and reports errors, the first failing address and timeouts.
module mem_wr_rd_master #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [ADDR_WIDTH:0]   num_locs_i,
  input  logic [WIDTH-1:0]      seed_i,
  mem_wr_rd_master_if.master    mem,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ADDR_WIDTH:0]   err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic                  timeout_o
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]         TLAST     = TW'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_N   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   ERR_MAX   = '1;

  typedef enum logic [2:0] {IDLE, WR, GAP, RD, DONE} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] start_q;
  logic [WIDTH-1:0]      seed_q;
  logic [ADDR_WIDTH:0]   n_q;
  logic [ADDR_WIDTH:0]   k_q;
  logic [WIDTH-1:0]      exp_q;
  logic [TW-1:0]         tcnt_q;

  logic                  handshake;
  logic                  last_xfer;
  logic                  mismatch;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH:0]   n_eff;
  logic [WIDTH-1:0]      exp_next;

  assign handshake = mem.valid_o & mem.ready_i;
  assign last_xfer = (k_q == (n_q - (ADDR_WIDTH + 1)'(1)));
  assign mismatch  = (mem.rdata_i != exp_q);
  assign exp_next  = exp_q + WIDTH'(1);
  // Explicit wrap so non-power-of-two depths still stay inside the memory
  assign next_addr = (mem.addr_o == LAST_ADDR) ? '0 : mem.addr_o + ADDR_WIDTH'(1);
  assign n_eff     = (num_locs_i > DEPTH_N) ? DEPTH_N : num_locs_i;

  // Control FSM; every output, including the bus request, is registered here
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q          <= IDLE;
      start_q          <= '0;
      seed_q           <= '0;
      n_q              <= '0;
      k_q              <= '0;
      exp_q            <= '0;
      tcnt_q           <= '0;
      mem.valid_o      <= 1'b0;
      mem.wr_rd_o      <= 1'b0;
      mem.addr_o       <= '0;
      mem.wdata_o      <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
      timeout_o        <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            start_q          <= start_addr_i;
            seed_q           <= seed_i;
            n_q              <= n_eff;
            k_q              <= '0;
            tcnt_q           <= '0;
            err_cnt_o        <= '0;
            first_err_addr_o <= '0;
            timeout_o        <= 1'b0;
            if (n_eff == '0) begin
              state_q <= DONE;
              done_o  <= 1'b1;
              pass_o  <= 1'b1;
            end else begin
              state_q     <= WR;
              busy_o      <= 1'b1;
              pass_o      <= 1'b0;
              mem.valid_o <= 1'b1;
              mem.wr_rd_o <= 1'b1;
              mem.addr_o  <= start_addr_i;
              mem.wdata_o <= seed_i;
              exp_q       <= seed_i;
            end
          end
        end

        WR, RD: begin
          if (handshake) begin
            tcnt_q <= '0;
            if (state_q == RD && mismatch) begin
              if (err_cnt_o != ERR_MAX) err_cnt_o <= err_cnt_o + (ADDR_WIDTH + 1)'(1);
              if (err_cnt_o == '0) first_err_addr_o <= mem.addr_o;
            end
            if (last_xfer) begin
              mem.valid_o <= 1'b0;
              mem.wdata_o <= '0;
              if (state_q == WR) begin
                // Rewind to the start of the range during the gap cycle
                state_q    <= GAP;
                mem.addr_o <= start_q;
                k_q        <= '0;
                exp_q      <= seed_q;
              end else begin
                state_q     <= DONE;
                busy_o      <= 1'b0;
                done_o      <= 1'b1;
                pass_o      <= (err_cnt_o == '0) && !mismatch;
                mem.wr_rd_o <= 1'b0;
                mem.addr_o  <= '0;
              end
            end else begin
              k_q        <= k_q + (ADDR_WIDTH + 1)'(1);
              mem.addr_o <= next_addr;
              exp_q      <= exp_next;
              if (state_q == WR) mem.wdata_o <= exp_next;
            end
          end else if (mem.valid_o) begin
            if (tcnt_q == TLAST) begin
              state_q     <= DONE;
              timeout_o   <= 1'b1;
              busy_o      <= 1'b0;
              done_o      <= 1'b1;
              pass_o      <= 1'b0;
              mem.valid_o <= 1'b0;
              mem.wr_rd_o <= 1'b0;
              mem.addr_o  <= '0;
              mem.wdata_o <= '0;
            end else begin
              tcnt_q <= tcnt_q + TW'(1);
            end
          end
        end

        GAP: begin
          state_q     <= RD;
          tcnt_q      <= '0;
          mem.valid_o <= 1'b1;
          mem.wr_rd_o <= 1'b0;
          mem.wdata_o <= '0;
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wr_rd_master.sv
// Directed bench for mem_wr_rd_master with a behavioural memory whose ready
// timing and read corruption are selectable per test.
module tb_mem_wr_rd_master;

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [15:0] data;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  start_addr;
  logic [6:0]  num_locs;
  logic [15:0] seed;
  logic        busy, done, pass, timeout;
  logic [6:0]  err_cnt;
  logic [5:0]  first_err_addr;

  int compared   = 0;
  int mismatched = 0;

  int    ready_mode = 0;
  int    stall_at   = 0;
  logic  corrupt    = 1'b0;
  int    wait_cnt   = 0;
  int    wr_total   = 0;
  int    rd_total   = 0;
  int    stall_total = 0;
  int    busy_total  = 0;
  int    gap_total   = 0;
  int    done_total  = 0;
  int    valid_total = 0;
  xfer_t log_q[$];
  logic [15:0] mem_model [64];

  mem_wr_rd_master_if #(.WIDTH(16), .ADDR_WIDTH(6)) bus();

  mem_wr_rd_master #(.WIDTH(16), .DEPTH(64), .ADDR_WIDTH(6), .TIMEOUT(8)) dut (
    .clk_i            (clk),
    .rst_i            (rst_n),
    .start_i          (start),
    .start_addr_i     (start_addr),
    .num_locs_i       (num_locs),
    .seed_i           (seed),
    .mem              (bus),
    .busy_o           (busy),
    .done_o           (done),
    .pass_o           (pass),
    .err_cnt_o        (err_cnt),
    .first_err_addr_o (first_err_addr),
    .timeout_o        (timeout)
  );

  always #5 clk = ~clk;

  // Memory model: mode 0 always ready, mode 1 one wait cycle, mode 2 stalls
  // once wr_total reaches stall_at
  assign bus.ready_i = bus.valid_o &&
                       ((ready_mode == 0) ||
                        (ready_mode == 1 && wait_cnt != 0) ||
                        (ready_mode == 2 && wr_total < stall_at));
  assign bus.rdata_i = mem_model[bus.addr_o] ^
                       ((corrupt && bus.addr_o == 6'd10) ? 16'h0001 : 16'h0000);

  always @(posedge clk) begin
    if (bus.valid_o && !bus.ready_i) begin
      wait_cnt    <= wait_cnt + 1;
      stall_total <= stall_total + 1;
    end else begin
      wait_cnt <= 0;
    end
    if (bus.valid_o && bus.ready_i) begin
      if (bus.wr_rd_o) begin
        mem_model[bus.addr_o] <= bus.wdata_o;
        wr_total <= wr_total + 1;
        log_q.push_back('{1'b1, bus.addr_o, bus.wdata_o});
      end else begin
        rd_total <= rd_total + 1;
        log_q.push_back('{1'b0, bus.addr_o, bus.rdata_i});
      end
    end
  end

  always @(negedge clk) begin
    if (busy) busy_total++;
    if (busy && !bus.valid_o) gap_total++;
    if (done) done_total++;
    if (bus.valid_o) valid_total++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start for one cycle, then wait (bounded) for done_o; cycles is
  // the number of falling edges from start to the done pulse
  task automatic applyStimulus(input logic [5:0] sa, input logic [6:0] n,
                               input logic [15:0] sd, output int cycles);
    @(negedge clk);
    start_addr = sa;
    num_locs   = n;
    seed       = sd;
    start      = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    while (!done && cycles < 3000) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int cyc;
    int b_log, b_busy, b_gap, b_stall, b_wr, b_rd, b_done, b_valid;
    int addrs[4];
    int datas[4];
    int w;
    addrs = '{62, 63, 0, 1};
    datas = '{32'hFFFE, 32'hFFFF, 32'h0000, 32'h0001};

    rst_n = 1'b0; start = 1'b0; start_addr = '0; num_locs = '0; seed = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    checkOutput("rst_busy",  {31'd0, busy}, 32'd0);
    checkOutput("rst_pass",  {31'd0, pass}, 32'd0);
    checkOutput("rst_err",   {25'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;

    // Single location, one wait cycle per transfer
    ready_mode = 1;
    b_log = log_q.size(); b_gap = gap_total;
    applyStimulus(6'd5, 7'd1, 16'hA5A5, cyc);
    checkOutput("t1_pass", {31'd0, pass}, 32'd1);
    checkOutput("t1_err", {25'd0, err_cnt}, 32'd0);
    checkOutput("t1_nxfer", log_q.size() - b_log, 32'd2);
    checkOutput("t1_wr", {31'd0, log_q[b_log].wr}, 32'd1);
    checkOutput("t1_waddr", {26'd0, log_q[b_log].addr}, 32'd5);
    checkOutput("t1_wdata", {16'd0, log_q[b_log].data}, 32'hA5A5);
    checkOutput("t1_rd", {31'd0, log_q[b_log+1].wr}, 32'd0);
    checkOutput("t1_raddr", {26'd0, log_q[b_log+1].addr}, 32'd5);
    checkOutput("t1_gap", gap_total - b_gap, 32'd1);

    // Sixteen back-to-back locations, ready tied high
    ready_mode = 0;
    b_log = log_q.size(); b_busy = busy_total; b_gap = gap_total;
    applyStimulus(6'd0, 7'd16, 16'h0000, cyc);
    checkOutput("t2_busy", busy_total - b_busy, 32'd33);
    checkOutput("t2_gap", gap_total - b_gap, 32'd1);
    checkOutput("t2_pass", {31'd0, pass}, 32'd1);
    checkOutput("t2_nxfer", log_q.size() - b_log, 32'd32);
    checkOutput("t2_wdata15", {16'd0, log_q[b_log+15].data}, 32'd15);
    checkOutput("t2_waddr15", {26'd0, log_q[b_log+15].addr}, 32'd15);
    checkOutput("t2_rd0_wr", {31'd0, log_q[b_log+16].wr}, 32'd0);
    checkOutput("t2_rd0_addr", {26'd0, log_q[b_log+16].addr}, 32'd0);

    // Address and data wrap
    b_log = log_q.size();
    applyStimulus(6'd62, 7'd4, 16'hFFFE, cyc);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t3_addr%0d", i), {26'd0, log_q[b_log+i].addr}, addrs[i]);
      checkOutput($sformatf("t3_data%0d", i), {16'd0, log_q[b_log+i].data}, datas[i]);
    end
    checkOutput("t3_rd_addr0", {26'd0, log_q[b_log+4].addr}, 32'd62);
    checkOutput("t3_pass", {31'd0, pass}, 32'd1);

    // Full depth with location 10 corrupted, then an oversized count
    corrupt = 1'b1;
    applyStimulus(6'd0, 7'd64, 16'h1234, cyc);
    checkOutput("t4_err", {25'd0, err_cnt}, 32'd1);
    checkOutput("t4_first", {26'd0, first_err_addr}, 32'd10);
    checkOutput("t4_pass", {31'd0, pass}, 32'd0);
    b_log = log_q.size();
    applyStimulus(6'd0, 7'd100, 16'h1234, cyc);
    checkOutput("t4b_nxfer", log_q.size() - b_log, 32'd128);
    checkOutput("t4b_err", {25'd0, err_cnt}, 32'd1);
    checkOutput("t4b_first", {26'd0, first_err_addr}, 32'd10);
    checkOutput("t4b_pass", {31'd0, pass}, 32'd0);
    corrupt = 1'b0;

    // Memory stops responding from the third write
    stall_at = wr_total + 2;
    ready_mode = 2;
    b_stall = stall_total; b_wr = wr_total; b_rd = rd_total;
    applyStimulus(6'd0, 7'd8, 16'h0100, cyc);
    checkOutput("t5_timeout", {31'd0, timeout}, 32'd1);
    checkOutput("t5_valid", {31'd0, bus.valid_o}, 32'd0);
    checkOutput("t5_pass", {31'd0, pass}, 32'd0);
    checkOutput("t5_stall", stall_total - b_stall, 32'd8);
    checkOutput("t5_writes", wr_total - b_wr, 32'd2);
    checkOutput("t5_reads", rd_total - b_rd, 32'd0);
    ready_mode = 0;

    // Reset in the middle of the read phase
    b_rd = rd_total;
    @(negedge clk);
    start_addr = 6'd0; num_locs = 7'd16; seed = 16'h0040; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while ((rd_total - b_rd) < 3 && w < 200) begin
      @(negedge clk);
      w++;
    end
    checkOutput("t6_reached_rd", {31'd0, (rd_total - b_rd) >= 3}, 32'd1);
    b_done = done_total;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_valid", {31'd0, bus.valid_o}, 32'd0);
    checkOutput("t6_busy", {31'd0, busy}, 32'd0);
    checkOutput("t6_addr", {26'd0, bus.addr_o}, 32'd0);
    checkOutput("t6_err", {25'd0, err_cnt}, 32'd0);
    checkOutput("t6_timeout", {31'd0, timeout}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t6_no_done", done_total - b_done, 32'd0);

    b_log = log_q.size();
    applyStimulus(6'd3, 7'd2, 16'h0007, cyc);
    checkOutput("t6_pass", {31'd0, pass}, 32'd1);
    checkOutput("t6_nxfer", log_q.size() - b_log, 32'd4);
    checkOutput("t6_wdata1", {16'd0, log_q[b_log+1].data}, 32'h0008);

    // Empty range completes immediately
    b_valid = valid_total; b_busy = busy_total;
    applyStimulus(6'd9, 7'd0, 16'h0000, cyc);
    checkOutput("t7_latency", cyc, 32'd1);
    checkOutput("t7_pass", {31'd0, pass}, 32'd1);
    checkOutput("t7_valid", valid_total - b_valid, 32'd0);
    checkOutput("t7_busy", busy_total - b_busy, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_wr_rd_master.md
Name: mem_wr_rd_master

Overview:
- Initiator side of the team's single-port memory valid/ready interface (the `memory` block).
- On a start command it writes a parameterised address range with a deterministic data pattern, then reads the range back and compares each word against the regenerated pattern.
- Reports pass/fail, error count, first failing address and handshake timeout.
- Sits between a test/control host and the memory; replaces bench-driven write/read sequences in system-level self-test.

Parameters:
- WIDTH, 16, data word width.
- DEPTH, 64, number of memory locations.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- TIMEOUT, 255, maximum cycles to wait for ready_i per transfer; must be ≥1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle command pulse; sampled only in IDLE.
- start_addr_i  in  ADDR_WIDTH  first location of the range.
- num_locs_i  in  ADDR_WIDTH+1  number of locations to test.
- seed_i  in  WIDTH  pattern seed.
- valid_o  out  1  request valid to memory.
- wr_rd_o  out  1  1 = write, 0 = read.
- addr_o  out  ADDR_WIDTH  request address.
- wdata_o  out  WIDTH  write data.
- rdata_i  in  WIDTH  read data from memory.
- ready_i  in  1  memory accepts/completes the current request.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  one-cycle completion pulse.
- pass_o  out  1  1 when error count is 0 and there was no timeout; valid when done_o fires.
- err_cnt_o  out  ADDR_WIDTH+1  number of read mismatches.
- first_err_addr_o  out  ADDR_WIDTH  address of the first mismatch; 0 if none.
- timeout_o  out  1  a transfer exceeded TIMEOUT cycles.

Behaviour:
- Reset (rst_i=0, async):
  - all outputs 0; FSM to IDLE.
  - Reset mid-operation aborts immediately; no done_o pulse.
- States and transitions:
  - IDLE: on start_i, latch start_addr_i, seed_i and effective N, where N = min(num_locs_i, DEPTH).
    - N=0: go to DONE directly with pass_o=1.
    - otherwise: clear err_cnt_o, first_err_addr_o and timeout_o, then go to WR.
  - WR: valid_o=1, wr_rd_o=1, addr_o=(start+k) mod DEPTH, wdata_o=seed+k mod 2^WIDTH, for k=0..N-1.
  - GAP: valid_o=0 for exactly 1 cycle; addr/k reset to start/0. Then go to RD.
  - RD: valid_o=1, wr_rd_o=0, same address sequence; wdata_o=0.
  - DONE: done_o=1 for one cycle; busy_o=0; then go to IDLE.
- Handshake:
  - A transfer completes on a rising edge where valid_o=1 and ready_i=1.
  - valid_o, wr_rd_o, addr_o and wdata_o are registered and held stable until completion.
  - On completion the next request is presented in the following cycle with valid_o still high (back-to-back, no bubble).
  - After the last write completes, go to GAP; after the last read completes, go to DONE.
- Read compare:
  - rdata_i is sampled in the completion cycle of each read and compared with seed+k.
  - On mismatch, err_cnt_o increments (saturates at 2^(ADDR_WIDTH+1)-1).
  - On the first mismatch only, first_err_addr_o captures addr_o.
- Address wrap: start+k wraps modulo DEPTH (e.g. start=62, N=4 → 62,63,0,1).
- Timeout:
  - A per-transfer counter starts at 0 on each new request and increments while valid_o=1 and ready_i=0.
  - On reaching TIMEOUT: set timeout_o=1, drop valid_o, go to DONE with pass_o=0. Remaining transfers are skipped.
- Results (pass_o, err_cnt_o, first_err_addr_o, timeout_o) are held until the next accepted start.
- start_i while busy is ignored.
- Simultaneous start_i and DONE: ignored (start is only accepted in IDLE).

Test Plan:
- start_addr=5, N=1, seed=16'hA5A5, memory ready after 1 cycle → one write (addr 5, data A5A5), 1 gap cycle, one read; done_o pulses; pass_o=1, err_cnt_o=0.
- start_addr=0, N=16, seed=0, ready tied high → 16 back-to-back writes of data 0..15, gap, 16 reads; total busy 33 cycles; pass_o=1.
- start_addr=62, N=4, seed=16'hFFFE → addresses 62,63,0,1 with data FFFE,FFFF,0000,0001; pass_o=1.
- N=64 with memory model corrupting location 10 (bit 0 flipped) → err_cnt_o=1, first_err_addr_o=10, pass_o=0; num_locs_i=100 behaves identically to 64.
- ready_i held low from the 3rd write, TIMEOUT=8 → timeout_o=1 after 8 waiting cycles, valid_o=0, done_o pulse, pass_o=0, no read phase.
- Assert rst_i low during the RD phase → all outputs 0 asynchronously, no done_o; a new start afterwards runs normally; N=0 start → done_o pulse on the next cycle, pass_o=1, valid_o never high.
